sd_boot_loader: RTL and testbench

//   Boot-time copy engine directly upstream of the SD card word reader (SDKarte).
//   On Start it issues WORD_COUNT sequential 32-bit word reads from SD word address
//   SD_START_WORD upward and writes each word to system RAM from RAM_BASE upward.
//   It keeps a running 32-bit additive checksum and reports completion or timeout.
//   It holds the CPU in reset (via Laedt) until the image is in RAM.

---
 rtl/sd_boot_loader.sv | 181 ++++++++++++++++++
 tb/tb_sd_boot_loader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_boot_loader.sv
// Boot copy engine: reads WORD_COUNT words from the SD word reader into RAM, summing them, holding the CPU off via Laedt.
// Latency: at least 5 cycles per word (REQ, DATA_WAIT, WR, WR_WAIT, REL_WAIT) plus SD and RAM handshake time.
// Backpressure: waits on SD_Busy/SD_Fertig and Mem_Bereit; any single wait longer than TIMEOUT cycles ends in ERROR.
module sd_boot_loader #(
  parameter logic [31:0] SD_START_WORD = 32'd0,
  parameter logic [31:0] WORD_COUNT    = 32'd1024,
  parameter logic [31:0] RAM_BASE      = 32'd0,
  parameter logic [31:0] TIMEOUT       = 32'd1000000
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Start,
  output logic        Laedt,
  output logic        Fertig_Laden,
  output logic        Fehler,
  output logic [31:0] Pruefsumme,
  output logic [31:0] SD_Adresse,
  output logic        SD_Lesen,
  input  logic [31:0] SD_Daten,
  input  logic        SD_Fertig,
  input  logic        SD_Busy,
  output logic [31:0] Mem_Adresse,
  output logic [31:0] Mem_Daten,
  output logic        Mem_Schreiben,
  input  logic        Mem_Bereit
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_DATA_WAIT,
    S_WR,
    S_WR_WAIT,
    S_REL_WAIT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state;
  logic [31:0] index;
  logic [31:0] timer;

  // One extra bit so TIMEOUT = 2^32-1 still compares correctly and TIMEOUT = 0 trips at once.
  logic [32:0] timer_inc;
  logic        timeout_hit;

  // Cycles spent in the current state, counting the cycle now ending.
  always_comb begin
    timer_inc   = {1'b0, timer} + 33'd1;
    timeout_hit = (timer_inc >= {1'b0, TIMEOUT});
  end

  // Copy sequencer; every output is a register so strobes and addresses are glitch-free.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= S_IDLE;
      index         <= '0;
      timer         <= '0;
      Laedt         <= 1'b0;
      Fertig_Laden  <= 1'b0;
      Fehler        <= 1'b0;
      Pruefsumme    <= '0;
      SD_Adresse    <= '0;
      SD_Lesen      <= 1'b0;
      Mem_Adresse   <= '0;
      Mem_Daten     <= '0;
      Mem_Schreiben <= 1'b0;
    end else begin
      // Default: keep counting; every state change below restarts the timer.
      timer <= timer_inc[31:0];

      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          timer <= '0;
          if (Start) begin
            index        <= '0;
            Pruefsumme   <= '0;
            Fertig_Laden <= 1'b0;
            Fehler       <= 1'b0;
            if (WORD_COUNT == 32'd0) begin
              state        <= S_DONE;
              Fertig_Laden <= 1'b1;
              Laedt        <= 1'b0;
            end else begin
              state <= S_REQ;
              Laedt <= 1'b1;
            end
          end
        end

        S_REQ: begin
          if (!SD_Busy) begin
            SD_Lesen   <= 1'b1;
            SD_Adresse <= SD_START_WORD + index;
            state      <= S_DATA_WAIT;
            timer      <= '0;
          end else if (timeout_hit) begin
            state         <= S_ERROR;
            timer         <= '0;
            Fehler        <= 1'b1;
            Laedt         <= 1'b0;
            SD_Lesen      <= 1'b0;
            Mem_Schreiben <= 1'b0;
          end
        end

        S_DATA_WAIT: begin
          // Leaving this state on the capture cycle is what makes the capture happen only once.
          if (SD_Fertig) begin
            Mem_Daten  <= SD_Daten;
            Pruefsumme <= Pruefsumme + SD_Daten;
            SD_Lesen   <= 1'b0;
            state      <= S_WR;
            timer      <= '0;
          end else if (timeout_hit) begin
            state         <= S_ERROR;
            timer         <= '0;
            Fehler        <= 1'b1;
            Laedt         <= 1'b0;
            SD_Lesen      <= 1'b0;
            Mem_Schreiben <= 1'b0;
          end
        end

        S_WR: begin
          Mem_Schreiben <= 1'b1;
          Mem_Adresse   <= RAM_BASE + index;
          state         <= S_WR_WAIT;
          timer         <= '0;
        end

        S_WR_WAIT: begin
          if (Mem_Bereit) begin
            Mem_Schreiben <= 1'b0;
            index         <= index + 32'd1;
            state         <= S_REL_WAIT;
            timer         <= '0;
          end else if (timeout_hit) begin
            state         <= S_ERROR;
            timer         <= '0;
            Fehler        <= 1'b1;
            Laedt         <= 1'b0;
            SD_Lesen      <= 1'b0;
            Mem_Schreiben <= 1'b0;
          end
        end

        S_REL_WAIT: begin
          // The reader keeps SD_Fertig high until its busy phase ends; wait that out
          // so the old data-valid is never mistaken for the next word.
          if (!SD_Busy) begin
            timer <= '0;
            if (index == WORD_COUNT) begin
              state        <= S_DONE;
              Fertig_Laden <= 1'b1;
              Laedt        <= 1'b0;
            end else begin
              state <= S_REQ;
            end
          end else if (timeout_hit) begin
            state         <= S_ERROR;
            timer         <= '0;
            Fehler        <= 1'b1;
            Laedt         <= 1'b0;
            SD_Lesen      <= 1'b0;
            Mem_Schreiben <= 1'b0;
          end
        end

        default: begin
          state         <= S_IDLE;
          timer         <= '0;
          Laedt         <= 1'b0;
          SD_Lesen      <= 1'b0;
          Mem_Schreiben <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_boot_loader.sv
// Directed bench for sd_boot_loader: two instances (default addressing, offset addressing)
// with a behavioural SD word reader and RAM per instance, all checks at negedge+1.
// Each check is an immediate assertion; the summary line reports checks and failures.
module tb_sd_boot_loader;

  logic        clk;
  logic        rst_n;

  logic        start     [2];
  logic        laedt     [2];
  logic        fertig    [2];
  logic        fehler    [2];
  logic [31:0] psum      [2];
  logic [31:0] sd_adr    [2];
  logic        sd_lesen  [2];
  logic [31:0] sd_dat    [2];
  logic        sd_fertig [2];
  logic        sd_busy   [2];
  logic [31:0] madr      [2];
  logic [31:0] mdat      [2];
  logic        mem_wr    [2];
  logic        bereit    [2];

  // model configuration (written by the stimulus only)
  int   sd_lat   [2] = '{1, 1};
  int   sd_hold  [2] = '{0, 0};
  int   sd_never [2] = '{0, 0};
  int   mem_lat  [2] = '{0, 0};
  logic clr      [2] = '{1'b0, 1'b0};

  // model state and logs (written by the model only)
  int          sd_st   [2] = '{0, 0};
  int          sd_cnt  [2] = '{0, 0};
  int          sd_hcnt [2] = '{0, 0};
  logic [31:0] sd_al   [2];
  int          wcnt    [2] = '{0, 0};
  logic [31:0] la      [2];
  logic [31:0] ld      [2];
  logic        les_q   [2] = '{1'b0, 1'b0};
  int          nrd     [2] = '{0, 0};
  int          nwr     [2] = '{0, 0};
  int          v_stab  [2] = '{0, 0};
  int          v_leswr [2] = '{0, 0};
  int          v_busy  [2] = '{0, 0};
  int          wr_len  [2] = '{0, 0};
  logic [31:0] rd_log  [2][16];
  logic [31:0] wa_log  [2][16];
  logic [31:0] wd_log  [2][16];

  int checks   = 0;
  int failures = 0;

  sd_boot_loader #(
    .SD_START_WORD(32'd0), .WORD_COUNT(32'd4), .RAM_BASE(32'd0), .TIMEOUT(32'd50)
  ) dut_a (
    .Clock(clk), .Reset_n(rst_n), .Start(start[0]), .Laedt(laedt[0]),
    .Fertig_Laden(fertig[0]), .Fehler(fehler[0]), .Pruefsumme(psum[0]),
    .SD_Adresse(sd_adr[0]), .SD_Lesen(sd_lesen[0]), .SD_Daten(sd_dat[0]),
    .SD_Fertig(sd_fertig[0]), .SD_Busy(sd_busy[0]), .Mem_Adresse(madr[0]),
    .Mem_Daten(mdat[0]), .Mem_Schreiben(mem_wr[0]), .Mem_Bereit(bereit[0])
  );

  sd_boot_loader #(
    .SD_START_WORD(32'd130), .WORD_COUNT(32'd2), .RAM_BASE(32'h100), .TIMEOUT(32'd1000)
  ) dut_b (
    .Clock(clk), .Reset_n(rst_n), .Start(start[1]), .Laedt(laedt[1]),
    .Fertig_Laden(fertig[1]), .Fehler(fehler[1]), .Pruefsumme(psum[1]),
    .SD_Adresse(sd_adr[1]), .SD_Lesen(sd_lesen[1]), .SD_Daten(sd_dat[1]),
    .SD_Fertig(sd_fertig[1]), .SD_Busy(sd_busy[1]), .Mem_Adresse(madr[1]),
    .Mem_Daten(mdat[1]), .Mem_Schreiben(mem_wr[1]), .Mem_Bereit(bereit[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SD reader and RAM models for both instances, updated on the falling edge
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        sd_st[g] = 0; sd_busy[g] = 1'b0; sd_fertig[g] = 1'b0; sd_dat[g] = '0;
        bereit[g] = 1'b0; wcnt[g] = 0; les_q[g] = 1'b0;
      end else begin
        if (clr[g]) begin
          nrd[g] = 0; nwr[g] = 0; v_stab[g] = 0; v_leswr[g] = 0; v_busy[g] = 0; wr_len[g] = 0;
        end
        if (sd_lesen[g] && !les_q[g] && sd_busy[g]) v_busy[g]++;
        les_q[g] = sd_lesen[g];
        case (sd_st[g])
          0: if (sd_lesen[g]) begin
               rd_log[g][nrd[g] % 16] = sd_adr[g];
               nrd[g]++;
               sd_al[g]   = sd_adr[g];
               sd_busy[g] = 1'b1;
               sd_cnt[g]  = sd_lat[g];
               sd_st[g]   = 1;
             end
          1: if (!sd_lesen[g]) begin
               sd_busy[g] = 1'b0;
               sd_st[g]   = 0;
             end else if (sd_never[g] == 0) begin
               sd_cnt[g]--;
               if (sd_cnt[g] <= 0) begin
                 sd_fertig[g] = 1'b1;
                 sd_dat[g]    = 32'h11111111 * sd_al[g];
                 sd_hcnt[g]   = sd_hold[g];
                 sd_st[g]     = 2;
               end
             end
          default: if (sd_hcnt[g] == 0) begin
               sd_busy[g]   = 1'b0;
               sd_fertig[g] = 1'b0;
               sd_st[g]     = 0;
             end else begin
               sd_hcnt[g]--;
             end
        endcase
        if (bereit[g]) begin
          bereit[g] = 1'b0;
        end else if (mem_wr[g]) begin
          if (wcnt[g] == 0) begin
            la[g] = madr[g];
            ld[g] = mdat[g];
          end else if (madr[g] !== la[g] || mdat[g] !== ld[g]) begin
            v_stab[g]++;
          end
          if (sd_lesen[g]) v_leswr[g]++;
          if (wcnt[g] >= mem_lat[g]) begin
            bereit[g] = 1'b1;
            wa_log[g][nwr[g] % 16] = madr[g];
            wd_log[g][nwr[g] % 16] = mdat[g];
            nwr[g]++;
            wr_len[g] = wcnt[g] + 1;
            wcnt[g]   = 0;
          end else begin
            wcnt[g]++;
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // pulse Start and clear the logs of instance g; Laedt must be up one cycle later
  task automatic kick(input int g, input string tag);
    clr[g]   = 1'b1;
    start[g] = 1'b1;
    step();
    clr[g]   = 1'b0;
    start[g] = 1'b0;
    chk({tag, "_laedt_up"}, {31'd0, laedt[g]}, 32'd1);
    chk({tag, "_fehler_clr"}, {31'd0, fehler[g]}, 32'd0);
  endtask

  task automatic wait_end(input int g, input int budget, input string tag);
    int n = 0;
    while (!(fertig[g] || fehler[g]) && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_ended"}, {31'd0, (fertig[g] || fehler[g])}, 32'd1);
  endtask

  // full 4-word copy on instance A with the 0x11111111*k data pattern
  task automatic chk_copy4(input string tag);
    chk({tag, "_fertig"}, {31'd0, fertig[0]}, 32'd1);
    chk({tag, "_fehler"}, {31'd0, fehler[0]}, 32'd0);
    chk({tag, "_laedt"},  {31'd0, laedt[0]},  32'd0);
    chk({tag, "_sum"},    psum[0], 32'h66666666);
    chk({tag, "_nrd"},    nrd[0], 32'd4);
    chk({tag, "_nwr"},    nwr[0], 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_rd_adr"}, rd_log[0][k], k);
      chk({tag, "_wr_adr"}, wa_log[0][k], k);
      chk({tag, "_wr_dat"}, wd_log[0][k], 32'h11111111 * k);
    end
  endtask

  initial begin
    int n;
    start[0] = 1'b0;
    start[1] = 1'b0;
    rst_n    = 1'b0;
    step();
    step();
    // reset state
    chk("rst_laedt",  {31'd0, laedt[0]},  32'd0);
    chk("rst_fertig", {31'd0, fertig[0]}, 32'd0);
    chk("rst_fehler", {31'd0, fehler[0]}, 32'd0);
    chk("rst_sum",    psum[0],   32'd0);
    chk("rst_sdadr",  sd_adr[0], 32'd0);
    chk("rst_lesen",  {31'd0, sd_lesen[0]}, 32'd0);
    chk("rst_memwr",  {31'd0, mem_wr[0]},   32'd0);
    chk("rst_madr",   madr[0], 32'd0);
    chk("rst_mdat",   mdat[0], 32'd0);
    rst_n = 1'b1;
    step();

    // 1: basic 4-word copy, RAM ready immediately
    kick(0, "t1");
    wait_end(0, 400, "t1");
    chk_copy4("t1");
    chk("t1_wr_len", wr_len[0], 32'd1);
    step();

    // 2: offset SD start and RAM base on instance B
    kick(1, "t2");
    wait_end(1, 400, "t2");
    chk("t2_fertig", {31'd0, fertig[1]}, 32'd1);
    chk("t2_nrd",  nrd[1], 32'd2);
    chk("t2_nwr",  nwr[1], 32'd2);
    chk("t2_rd0",  rd_log[1][0], 32'd130);
    chk("t2_rd1",  rd_log[1][1], 32'd131);
    chk("t2_wa0",  wa_log[1][0], 32'h100);
    chk("t2_wa1",  wa_log[1][1], 32'h101);
    chk("t2_wd0",  wd_log[1][0], 32'h11111111 * 32'd130);
    chk("t2_wd1",  wd_log[1][1], 32'h11111111 * 32'd131);
    chk("t2_sum",  psum[1], 32'h11111111 * 32'd261);
    step();

    // 3: RAM accepts only after 7 extra cycles
    mem_lat[0] = 7;
    kick(0, "t3");
    wait_end(0, 600, "t3");
    chk_copy4("t3");
    chk("t3_wr_len",  wr_len[0],  32'd8);
    chk("t3_stable",  v_stab[0],  32'd0);
    chk("t3_lesen_0", v_leswr[0], 32'd0);
    mem_lat[0] = 0;
    step();

    // 4: SD_Fertig held 20 extra cycles with SD_Busy still high
    sd_hold[0] = 20;
    kick(0, "t4");
    wait_end(0, 800, "t4");
    chk_copy4("t4");
    chk("t4_lesen_busy", v_busy[0], 32'd0);
    sd_hold[0] = 0;
    step();

    // 5: SD never delivers; timeout after 50 cycles in DATA_WAIT
    sd_never[0] = 1;
    kick(0, "t5");
    n = 0;
    while (!sd_lesen[0] && n < 20) begin
      step();
      n++;
    end
    chk("t5_lesen_up", {31'd0, sd_lesen[0]}, 32'd1);
    n = 0;
    while (!fehler[0] && n < 200) begin
      step();
      n++;
    end
    chk("t5_tmo_cycles", n, 32'd50);
    chk("t5_fehler", {31'd0, fehler[0]},   32'd1);
    chk("t5_lesen",  {31'd0, sd_lesen[0]}, 32'd0);
    chk("t5_laedt",  {31'd0, laedt[0]},    32'd0);
    chk("t5_fertig", {31'd0, fertig[0]},   32'd0);
    sd_never[0] = 0;
    step();
    step();
    kick(0, "t5r");
    wait_end(0, 400, "t5r");
    chk_copy4("t5r");

    // 6: reset during WR_WAIT of word 2
    mem_lat[0] = 7;
    kick(0, "t6");
    n = 0;
    while (!(mem_wr[0] && madr[0] == 32'd2) && n < 400) begin
      step();
      n++;
    end
    chk("t6_in_wr2", {31'd0, (mem_wr[0] && madr[0] == 32'd2)}, 32'd1);
    step();
    rst_n = 1'b0;
    #1;
    chk("t6_memwr", {31'd0, mem_wr[0]},   32'd0);
    chk("t6_laedt", {31'd0, laedt[0]},    32'd0);
    chk("t6_lesen", {31'd0, sd_lesen[0]}, 32'd0);
    chk("t6_sum",   psum[0], 32'd0);
    chk("t6_madr",  madr[0], 32'd0);
    chk("t6_mdat",  mdat[0], 32'd0);
    step();
    step();
    rst_n = 1'b1;
    mem_lat[0] = 0;
    step();
    kick(0, "t6r");
    wait_end(0, 400, "t6r");
    chk_copy4("t6r");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
